// File: rtl/stage_execute_if.sv
// Registered execute-to-memory bundle of the RV32IM pipeline.
// master: stage_execute drives it; slave: stage_memory samples it.
interface stage_execute_if;
    logic [4:0]  execute_rd;
    logic        execute_regfile_wr_enable;
    logic [31:0] execute_alu_result;
    logic [31:0] execute_instr_addr_plus;
    logic [1:0]  execute_result_src;
    logic        execute_datamem_wr_enable;
    logic [2:0]  execute_funct3;
    logic [31:0] execute_wr_datamem_data;

    modport master (
        output execute_rd, execute_regfile_wr_enable, execute_alu_result,
               execute_instr_addr_plus, execute_result_src, execute_datamem_wr_enable,
               execute_funct3, execute_wr_datamem_data
    );
    modport slave (
        input  execute_rd, execute_regfile_wr_enable, execute_alu_result,
               execute_instr_addr_plus, execute_result_src, execute_datamem_wr_enable,
               execute_funct3, execute_wr_datamem_data
    );
endinterface

// File: rtl/stage_execute.sv
// RV32IM execute stage: forwarding, ALU/MUL, branch resolution, optional divider.
// Define EXECUTE_DIV_EN to build the iterative radix-2 divider FSM.
module stage_execute (
    input  logic        aclk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] decode_rd1,
    input  logic [31:0] decode_rd2,
    input  logic [4:0]  decode_rs1,
    input  logic [4:0]  decode_rs2,
    input  logic [4:0]  decode_rd,
    input  logic [31:0] decode_imm,
    input  logic [31:0] decode_instr_addr,
    input  logic [31:0] decode_instr_addr_plus,
    input  logic [4:0]  decode_alu_op,
    input  logic        decode_alu_src,
    input  logic        decode_branch,
    input  logic        decode_jump,
    input  logic        decode_jalr,
    input  logic [2:0]  decode_funct3,
    input  logic [1:0]  decode_result_src,
    input  logic        decode_regfile_wr_enable,
    input  logic        decode_datamem_wr_enable,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regfile_wr_enable,
    input  logic [31:0] mem_alu_result,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regfile_wr_enable,
    input  logic [31:0] wb_write_data,
    output logic        pc_src,
    output logic [31:0] branch_target,
    output logic        stall,
    stage_execute_if.master mem_bus
);
    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
    localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_MUL = 5'd16, OP_MULH = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18, OP_MULHU = 5'd19;

    logic [31:0] fwd_a, fwd_b, op_b;

    // The memory stage holds the younger result, so it outranks writeback.
    always_comb begin
        fwd_a = decode_rd1;
        if (mem_regfile_wr_enable && (mem_rd == decode_rs1) && (decode_rs1 != 5'd0))
            fwd_a = mem_alu_result;
        else if (wb_regfile_wr_enable && (wb_rd == decode_rs1) && (decode_rs1 != 5'd0))
            fwd_a = wb_write_data;
    end

    always_comb begin
        fwd_b = decode_rd2;
        if (mem_regfile_wr_enable && (mem_rd == decode_rs2) && (decode_rs2 != 5'd0))
            fwd_b = mem_alu_result;
        else if (wb_regfile_wr_enable && (wb_rd == decode_rs2) && (decode_rs2 != 5'd0))
            fwd_b = wb_write_data;
    end

    assign op_b = decode_alu_src ? decode_imm : fwd_b;

    // One 64-bit product; operand extension picks signed/unsigned flavour.
    logic        mul_a_signed, mul_b_signed;
    logic [63:0] mul_a, mul_b, product;
    assign mul_a_signed = (decode_alu_op == OP_MULH) || (decode_alu_op == OP_MULHSU);
    assign mul_b_signed = (decode_alu_op == OP_MULH);
    assign mul_a   = {{32{mul_a_signed & fwd_a[31]}}, fwd_a};
    assign mul_b   = {{32{mul_b_signed & op_b[31]}}, op_b};
    assign product = mul_a * mul_b;

    logic [31:0] alu_result;
    always_comb begin
        alu_result = 32'd0;
        case (decode_alu_op)
            OP_ADD:    alu_result = fwd_a + op_b;
            OP_SUB:    alu_result = fwd_a - op_b;
            OP_SLL:    alu_result = fwd_a << op_b[4:0];
            OP_SLT:    alu_result = {31'd0, ($signed(fwd_a) < $signed(op_b))};
            OP_SLTU:   alu_result = {31'd0, (fwd_a < op_b)};
            OP_XOR:    alu_result = fwd_a ^ op_b;
            OP_SRL:    alu_result = fwd_a >> op_b[4:0];
            OP_SRA:    alu_result = $unsigned($signed(fwd_a) >>> op_b[4:0]);
            OP_OR:     alu_result = fwd_a | op_b;
            OP_AND:    alu_result = fwd_a & op_b;
            OP_MUL:    alu_result = product[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU: alu_result = product[63:32];
            default:   alu_result = 32'd0;
        endcase
    end

    logic taken;
    always_comb begin
        taken = 1'b0;
        case (decode_funct3)
            3'b000:  taken = (fwd_a == fwd_b);
            3'b001:  taken = (fwd_a != fwd_b);
            3'b100:  taken = ($signed(fwd_a) <  $signed(fwd_b));
            3'b101:  taken = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  taken = (fwd_a <  fwd_b);
            3'b111:  taken = (fwd_a >= fwd_b);
            default: taken = 1'b0;
        endcase
    end

    logic [31:0] target_sum;
    assign target_sum    = (decode_jalr ? fwd_a : decode_instr_addr) + decode_imm;
    assign branch_target = decode_jalr ? {target_sum[31:1], 1'b0} : target_sum;
    assign pc_src        = !flush && !stall && (decode_jump || (decode_branch && taken));

    logic        is_div_op, div_done, issue_wr_enable;
    logic [31:0] div_result, issue_result;
    assign is_div_op = (decode_alu_op[4:2] == 3'b101);

`ifdef EXECUTE_DIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;
    div_state_t  state_reg, state_next;
    logic [4:0]  count_reg;
    logic [31:0] rem_reg, quo_reg, divisor_reg;
    logic        negate_reg, rem_sel_reg;
    logic        div_signed, div_rem_sel, div_by_zero, div_overflow, div_special, div_issue;
    logic [31:0] special_result;
    logic [32:0] rem_shift, rem_diff;

    assign div_signed     = ~decode_alu_op[0];
    assign div_rem_sel    = decode_alu_op[1];
    assign div_by_zero    = (fwd_b == 32'd0);
    assign div_overflow   = div_signed && (fwd_a == 32'h8000_0000) && (fwd_b == 32'hFFFF_FFFF);
    assign div_special    = div_by_zero || div_overflow;
    assign special_result = div_by_zero ? (div_rem_sel ? fwd_a : 32'hFFFF_FFFF)
                                        : (div_rem_sel ? 32'd0 : 32'h8000_0000);
    assign div_issue = (state_reg == IDLE) && is_div_op && !div_special && !flush;
    assign stall     = div_issue || (state_reg == BUSY);
    assign div_done  = (state_reg == DONE);

    always_ff @(posedge aclk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (div_issue) state_next = BUSY;
            BUSY:    if (count_reg == 5'd31) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Restoring shift-subtract on magnitudes; signs are reapplied in DONE.
    assign rem_shift = {rem_reg, quo_reg[31]};
    assign rem_diff  = rem_shift - {1'b0, divisor_reg};

    always_ff @(posedge aclk) begin
        if (rst) begin
            count_reg   <= 5'd0;
            rem_reg     <= 32'd0;
            quo_reg     <= 32'd0;
            divisor_reg <= 32'd0;
            negate_reg  <= 1'b0;
            rem_sel_reg <= 1'b0;
        end else if (div_issue) begin
            count_reg   <= 5'd0;
            rem_reg     <= 32'd0;
            quo_reg     <= (div_signed && fwd_a[31]) ? -fwd_a : fwd_a;
            divisor_reg <= (div_signed && fwd_b[31]) ? -fwd_b : fwd_b;
            rem_sel_reg <= div_rem_sel;
            negate_reg  <= div_signed && (div_rem_sel ? fwd_a[31] : (fwd_a[31] ^ fwd_b[31]));
        end else if (state_reg == BUSY) begin
            count_reg <= count_reg + 5'd1;
            if (!rem_diff[32]) begin
                rem_reg <= rem_diff[31:0];
                quo_reg <= {quo_reg[30:0], 1'b1};
            end else begin
                rem_reg <= rem_shift[31:0];
                quo_reg <= {quo_reg[30:0], 1'b0};
            end
        end
    end

    always_comb begin
        div_result = rem_sel_reg ? rem_reg : quo_reg;
        if (negate_reg) div_result = -div_result;
    end

    assign issue_result    = is_div_op ? special_result : alu_result;
    assign issue_wr_enable = decode_regfile_wr_enable;
`else
    assign stall           = 1'b0;
    assign div_done        = 1'b0;
    assign div_result      = 32'd0;
    assign issue_result    = is_div_op ? 32'd0 : alu_result;
    assign issue_wr_enable = decode_regfile_wr_enable && !is_div_op;
`endif

    // Stalled edges load bubbles; the divide result lands on the DONE edge.
    always_ff @(posedge aclk) begin
        if (rst || flush || stall) begin
            mem_bus.execute_rd                <= 5'd0;
            mem_bus.execute_regfile_wr_enable <= 1'b0;
            mem_bus.execute_alu_result        <= 32'd0;
            mem_bus.execute_instr_addr_plus   <= 32'd0;
            mem_bus.execute_result_src        <= 2'd0;
            mem_bus.execute_datamem_wr_enable <= 1'b0;
            mem_bus.execute_funct3            <= 3'd0;
            mem_bus.execute_wr_datamem_data   <= 32'd0;
        end else begin
            mem_bus.execute_rd                <= decode_rd;
            mem_bus.execute_regfile_wr_enable <= div_done ? decode_regfile_wr_enable : issue_wr_enable;
            mem_bus.execute_alu_result        <= div_done ? div_result : issue_result;
            mem_bus.execute_instr_addr_plus   <= decode_instr_addr_plus;
            mem_bus.execute_result_src        <= decode_result_src;
            mem_bus.execute_datamem_wr_enable <= decode_datamem_wr_enable;
            mem_bus.execute_funct3            <= decode_funct3;
            mem_bus.execute_wr_datamem_data   <= fwd_b;
        end
    end
endmodule

// File: tb/tb_stage_execute.sv
// Directed and randomized bench for stage_execute against an arithmetic reference model.
module tb_stage_execute;
`ifdef EXECUTE_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        aclk = 1'b0;
    logic        rst, flush;
    logic [31:0] decode_rd1, decode_rd2, decode_imm, decode_instr_addr, decode_instr_addr_plus;
    logic [4:0]  decode_rs1, decode_rs2, decode_rd, decode_alu_op;
    logic        decode_alu_src, decode_branch, decode_jump, decode_jalr;
    logic [2:0]  decode_funct3;
    logic [1:0]  decode_result_src;
    logic        decode_regfile_wr_enable, decode_datamem_wr_enable;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_regfile_wr_enable, wb_regfile_wr_enable;
    logic [31:0] mem_alu_result, wb_write_data;
    logic        pc_src, stall;
    logic [31:0] branch_target;

    int vectors = 0;
    int miscompares = 0;

    always #5 aclk = ~aclk;

    stage_execute_if ex_bus ();

    stage_execute dut (
        .aclk(aclk), .rst(rst), .flush(flush),
        .decode_rd1(decode_rd1), .decode_rd2(decode_rd2),
        .decode_rs1(decode_rs1), .decode_rs2(decode_rs2), .decode_rd(decode_rd),
        .decode_imm(decode_imm), .decode_instr_addr(decode_instr_addr),
        .decode_instr_addr_plus(decode_instr_addr_plus),
        .decode_alu_op(decode_alu_op), .decode_alu_src(decode_alu_src),
        .decode_branch(decode_branch), .decode_jump(decode_jump), .decode_jalr(decode_jalr),
        .decode_funct3(decode_funct3), .decode_result_src(decode_result_src),
        .decode_regfile_wr_enable(decode_regfile_wr_enable),
        .decode_datamem_wr_enable(decode_datamem_wr_enable),
        .mem_rd(mem_rd), .mem_regfile_wr_enable(mem_regfile_wr_enable),
        .mem_alu_result(mem_alu_result),
        .wb_rd(wb_rd), .wb_regfile_wr_enable(wb_regfile_wr_enable),
        .wb_write_data(wb_write_data),
        .pc_src(pc_src), .branch_target(branch_target), .stall(stall),
        .mem_bus(ex_bus)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic idle_inputs();
        flush = 0;
        decode_rd1 = 0; decode_rd2 = 0; decode_rs1 = 0; decode_rs2 = 0; decode_rd = 0;
        decode_imm = 0; decode_instr_addr = 0; decode_instr_addr_plus = 0;
        decode_alu_op = 0; decode_alu_src = 0; decode_branch = 0; decode_jump = 0; decode_jalr = 0;
        decode_funct3 = 0; decode_result_src = 0;
        decode_regfile_wr_enable = 0; decode_datamem_wr_enable = 0;
        mem_rd = 0; mem_regfile_wr_enable = 0; mem_alu_result = 0;
        wb_rd = 0; wb_regfile_wr_enable = 0; wb_write_data = 0;
    endtask

    function automatic logic [31:0] fwd_model(input logic [4:0] rs, input logic [31:0] rf_val);
        if (rs != 0 && mem_regfile_wr_enable && mem_rd == rs) return mem_alu_result;
        if (rs != 0 && wb_regfile_wr_enable && wb_rd == rs) return wb_write_data;
        return rf_val;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] q, r;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'(a);          ub = longint'(b);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd4:  return (a < b) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  return 32'($signed(a) >>> b[4:0]);
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd16: begin p = 64'(sa * sb); return p[31:0];  end
            5'd17: begin p = 64'(sa * sb); return p[63:32]; end
            5'd18: begin p = 64'(sa * ub); return p[63:32]; end
            5'd19: begin p = 64'(ua * ub); return p[63:32]; end
            5'd20, 5'd21, 5'd22, 5'd23: begin
                if (!DIV_EN) return 32'd0;
                if (b == 0) begin
                    q = 32'hFFFF_FFFF; r = a;
                end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000; r = 0;
                end else if (!op[0]) begin
                    q = 32'(sa / sb); r = 32'(sa % sb);
                end else begin
                    q = a / b; r = a % b;
                end
                return op[1] ? r : q;
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) <  $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] rnd_word();
        logic [31:0] edges [6] = '{32'd0, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1F};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
        return $urandom();
    endfunction

    // Checks one single-cycle instruction whose inputs are already applied.
    task automatic alu_txn(input string tag);
        logic [31:0] fa, fb, b, exp;
        logic        exp_we, div_op;
        fa = fwd_model(decode_rs1, decode_rd1);
        fb = fwd_model(decode_rs2, decode_rd2);
        b  = decode_alu_src ? decode_imm : fb;
        div_op = (decode_alu_op >= 5'd20) && (decode_alu_op <= 5'd23);
        exp    = ref_alu(decode_alu_op, fa, b);
        exp_we = decode_regfile_wr_enable && (DIV_EN || !div_op);
        #2;
        check({tag, ":stall"}, 32'(stall), 32'd0);
        @(posedge aclk); #1;
        check({tag, ":res"},   ex_bus.execute_alu_result, exp);
        check({tag, ":we"},    32'(ex_bus.execute_regfile_wr_enable), 32'(exp_we));
        check({tag, ":rd"},    32'(ex_bus.execute_rd), 32'(decode_rd));
        check({tag, ":sdata"}, ex_bus.execute_wr_datamem_data, fb);
        check({tag, ":pc4"},   ex_bus.execute_instr_addr_plus, decode_instr_addr_plus);
        check({tag, ":dwe"},   32'(ex_bus.execute_datamem_wr_enable), 32'(decode_datamem_wr_enable));
        $display("txn %s op=%0d a=%h b=%h -> res=%h we=%0d", tag, decode_alu_op, fa, b,
                 ex_bus.execute_alu_result, ex_bus.execute_regfile_wr_enable);
    endtask

    task automatic div_run(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n_stall, n_bubble;
        logic [31:0] exp;
        idle_inputs();
        decode_alu_op = op; decode_rs1 = 5'd1; decode_rd1 = a; decode_rs2 = 5'd2; decode_rd2 = b;
        decode_rd = 5'd9; decode_regfile_wr_enable = 1;
        exp = ref_alu(op, a, b);
        n_stall = 0; n_bubble = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (stall !== 1'b1) break;
            n_stall++;
            @(posedge aclk); #1;
            if (ex_bus.execute_regfile_wr_enable === 1'b0) n_bubble++;
            // Forwarding sources wander while busy; the latched operands must win.
            mem_regfile_wr_enable = 1; mem_rd = 5'd1; mem_alu_result = $urandom();
        end
        check({tag, ":stall_cycles"}, 32'(n_stall), 32'd33);
        check({tag, ":bubbles"}, 32'(n_bubble), 32'd33);
        @(posedge aclk); #1;
        check({tag, ":res"}, ex_bus.execute_alu_result, exp);
        check({tag, ":we"}, 32'(ex_bus.execute_regfile_wr_enable), 32'd1);
        $display("txn %s op=%0d a=%h b=%h stall=%0d -> res=%h", tag, op, a, b, n_stall,
                 ex_bus.execute_alu_result);
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] alu_ops [14] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                     5'd8, 5'd9, 5'd16, 5'd17, 5'd18, 5'd19};
        logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [31:0] fa, fb, exp_tgt;
        logic exp_pc;
        int kind, n_bad;

        // Reset must win over live, nonzero decode inputs.
        idle_inputs();
        rst = 1;
        decode_rd = 5'd7; decode_rd1 = 32'h1234; decode_regfile_wr_enable = 1;
        decode_datamem_wr_enable = 1; decode_instr_addr_plus = 32'h104;
        decode_result_src = 2'd2; decode_funct3 = 3'd2;
        repeat (3) @(posedge aclk);
        #1;
        check("rst:rd",  32'(ex_bus.execute_rd), 32'd0);
        check("rst:we",  32'(ex_bus.execute_regfile_wr_enable), 32'd0);
        check("rst:res", ex_bus.execute_alu_result, 32'd0);
        check("rst:pc4", ex_bus.execute_instr_addr_plus, 32'd0);
        check("rst:dwe", 32'(ex_bus.execute_datamem_wr_enable), 32'd0);
        check("rst:f3",  32'(ex_bus.execute_funct3), 32'd0);
        $display("txn reset");
        rst = 0;

        idle_inputs();
        decode_rs1 = 5'd5; decode_rd1 = 32'd1; decode_imm = 32'd3; decode_alu_src = 1;
        decode_rd = 5'd3; decode_regfile_wr_enable = 1;
        mem_rd = 5'd5; mem_regfile_wr_enable = 1; mem_alu_result = 32'd7;
        wb_rd = 5'd5; wb_regfile_wr_enable = 1; wb_write_data = 32'd9;
        alu_txn("fwd_prio");
        check("fwd_prio:const", ex_bus.execute_alu_result, 32'd10);

        idle_inputs();
        decode_rs1 = 5'd0; decode_rd1 = 32'h40; decode_rs2 = 5'd0; decode_rd2 = 32'h2;
        mem_rd = 5'd0; mem_regfile_wr_enable = 1; mem_alu_result = 32'hDEAD;
        decode_rd = 5'd4; decode_regfile_wr_enable = 1;
        alu_txn("x0_nofwd");
        check("x0_nofwd:const", ex_bus.execute_alu_result, 32'h42);

        idle_inputs();
        decode_alu_op = 5'd19; decode_rs1 = 5'd1; decode_rd1 = 32'hFFFF_FFFF;
        decode_rs2 = 5'd2; decode_rd2 = 32'hFFFF_FFFF; decode_rd = 5'd6; decode_regfile_wr_enable = 1;
        alu_txn("mulhu");
        check("mulhu:const", ex_bus.execute_alu_result, 32'hFFFF_FFFE);

        for (int i = 0; i < 80; i++) begin
            idle_inputs();
            decode_alu_op = alu_ops[$urandom_range(0, 13)];
            decode_rs1 = 5'($urandom_range(0, 3)); decode_rs2 = 5'($urandom_range(0, 3));
            decode_rd = 5'($urandom_range(1, 31));
            decode_rd1 = rnd_word(); decode_rd2 = rnd_word(); decode_imm = rnd_word();
            decode_alu_src = 1'($urandom_range(0, 1));
            mem_rd = 5'($urandom_range(0, 3)); mem_regfile_wr_enable = 1'($urandom_range(0, 1));
            mem_alu_result = rnd_word();
            wb_rd = 5'($urandom_range(0, 3)); wb_regfile_wr_enable = 1'($urandom_range(0, 1));
            wb_write_data = rnd_word();
            decode_regfile_wr_enable = 1'($urandom_range(0, 1));
            decode_datamem_wr_enable = 1'($urandom_range(0, 1));
            decode_instr_addr_plus = $urandom();
            decode_funct3 = 3'($urandom_range(0, 7));
            alu_txn("rnd_alu");
        end

        idle_inputs();
        decode_branch = 1; decode_funct3 = 3'd4;
        decode_rs1 = 5'd1; decode_rd1 = 32'hFFFF_FFFF; decode_rs2 = 5'd2; decode_rd2 = 32'd1;
        decode_instr_addr = 32'h100; decode_imm = 32'h20;
        #1;
        check("blt:pc_src", 32'(pc_src), 32'd1);
        check("blt:target", branch_target, 32'h120);
        decode_funct3 = 3'd6;
        #1;
        check("bltu:pc_src", 32'(pc_src), 32'd0);
        $display("txn blt/bltu pc=100 imm=20");

        decode_funct3 = 3'd4; flush = 1;
        decode_regfile_wr_enable = 1; decode_datamem_wr_enable = 1;
        #1;
        check("flush:pc_src", 32'(pc_src), 32'd0);
        @(posedge aclk); #1;
        check("flush:we",  32'(ex_bus.execute_regfile_wr_enable), 32'd0);
        check("flush:dwe", 32'(ex_bus.execute_datamem_wr_enable), 32'd0);
        $display("txn flushed blt");

        for (int i = 0; i < 40; i++) begin
            idle_inputs();
            kind = $urandom_range(0, 2);
            decode_branch = (kind == 0); decode_jump = (kind != 0); decode_jalr = (kind == 2);
            decode_funct3 = br_f3[$urandom_range(0, 5)];
            decode_rs1 = 5'($urandom_range(0, 3)); decode_rs2 = 5'($urandom_range(0, 3));
            decode_rd1 = rnd_word();
            decode_rd2 = ($urandom_range(0, 3) == 0) ? decode_rd1 : rnd_word();
            decode_imm = $urandom(); decode_instr_addr = $urandom();
            mem_rd = 5'($urandom_range(0, 3)); mem_regfile_wr_enable = 1'($urandom_range(0, 1));
            mem_alu_result = rnd_word();
            wb_rd = 5'($urandom_range(0, 3)); wb_regfile_wr_enable = 1'($urandom_range(0, 1));
            wb_write_data = rnd_word();
            fa = fwd_model(decode_rs1, decode_rd1);
            fb = fwd_model(decode_rs2, decode_rd2);
            exp_pc  = decode_jump || (decode_branch && ref_taken(decode_funct3, fa, fb));
            exp_tgt = decode_jalr ? ((fa + decode_imm) & ~32'd1) : (decode_instr_addr + decode_imm);
            #1;
            check("rnd_br:pc_src", 32'(pc_src), 32'(exp_pc));
            check("rnd_br:target", branch_target, exp_tgt);
            $display("txn branch kind=%0d f3=%0d a=%h b=%h -> pc_src=%0d tgt=%h",
                     kind, decode_funct3, fa, fb, pc_src, branch_target);
            @(posedge aclk); #1;
        end

        // Divide special cases complete in one cycle (or are killed without the divider).
        idle_inputs();
        decode_alu_op = 5'd21; decode_rs1 = 5'd1; decode_rd1 = 32'h1234; decode_rs2 = 5'd2;
        decode_rd = 5'd8; decode_regfile_wr_enable = 1;
        alu_txn("divu_by0");
        decode_alu_op = 5'd23;
        alu_txn("remu_by0");
        decode_alu_op = 5'd20; decode_rd1 = 32'h8000_0000; decode_rd2 = 32'hFFFF_FFFF;
        alu_txn("div_ovf");
        decode_alu_op = 5'd22;
        alu_txn("rem_ovf");

`ifdef EXECUTE_DIV_EN
        div_run("div_m7_2", 5'd20, 32'hFFFF_FFF9, 32'd2);
        check("div_m7_2:const", ex_bus.execute_alu_result, 32'hFFFF_FFFD);
        div_run("rem_m7_2", 5'd22, 32'hFFFF_FFF9, 32'd2);
        check("rem_m7_2:const", ex_bus.execute_alu_result, 32'hFFFF_FFFF);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a, b;
            logic [4:0]  op;
            op = 5'(20 + $urandom_range(0, 3));
            a = rnd_word(); b = rnd_word();
            if (b == 0) b = 32'd3;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd5;
            div_run("rnd_div", op, a, b);
        end

        // Flush in the middle of a divide.
        idle_inputs();
        decode_alu_op = 5'd20; decode_rs1 = 5'd1; decode_rd1 = 32'hFFFF_FFF9;
        decode_rs2 = 5'd2; decode_rd2 = 32'd2; decode_rd = 5'd9; decode_regfile_wr_enable = 1;
        repeat (11) @(posedge aclk);
        #1;
        check("flush_div:busy_stall", 32'(stall), 32'd1);
        flush = 1;
        @(posedge aclk); #1;
        idle_inputs();
        decode_rd = 5'd4; decode_regfile_wr_enable = 1;
        #1;
        check("flush_div:stall_next", 32'(stall), 32'd0);
        n_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge aclk); #1;
            if (ex_bus.execute_alu_result !== 32'd0 || stall !== 1'b0) n_bad++;
        end
        check("flush_div:no_result", 32'(n_bad), 32'd0);
        $display("txn flush during divide");

        // Reset in the middle of a divide.
        idle_inputs();
        decode_alu_op = 5'd21; decode_rs1 = 5'd1; decode_rd1 = 32'd1000;
        decode_rs2 = 5'd2; decode_rd2 = 32'd7; decode_rd = 5'd9; decode_regfile_wr_enable = 1;
        repeat (6) @(posedge aclk);
        #1;
        check("rst_div:busy_stall", 32'(stall), 32'd1);
        rst = 1;
        idle_inputs();
        decode_rd = 5'd12; decode_rd1 = 32'h55; decode_regfile_wr_enable = 1;
        decode_datamem_wr_enable = 1; decode_instr_addr_plus = 32'h200;
        @(posedge aclk); #1;
        check("rst_div:res",  ex_bus.execute_alu_result, 32'd0);
        check("rst_div:we",   32'(ex_bus.execute_regfile_wr_enable), 32'd0);
        check("rst_div:rd",   32'(ex_bus.execute_rd), 32'd0);
        check("rst_div:pc4",  ex_bus.execute_instr_addr_plus, 32'd0);
        check("rst_div:stall", 32'(stall), 32'd0);
        rst = 0;
        @(posedge aclk); #1;
        check("rst_div:recover", ex_bus.execute_alu_result, 32'h55);
        $display("txn reset during divide");
`else
        idle_inputs();
        decode_alu_op = 5'd20; decode_rs1 = 5'd1; decode_rd1 = 32'hFFFF_FFF9;
        decode_rs2 = 5'd2; decode_rd2 = 32'd2; decode_rd = 5'd9; decode_regfile_wr_enable = 1;
        alu_txn("div_off");
        decode_alu_op = 5'd22;
        alu_txn("rem_off");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
